// File: rtl/colpar_pkg.sv
// Shared constants, FSM state type and column-parity helper for the slice-serial theta engine.
package colpar_pkg;

  localparam int unsigned NX     = 5;
  localparam int unsigned NY     = 5;
  localparam int unsigned LINE_W = 25;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD0  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // C[x] = XOR over y of slice bit 5*y+x
  function automatic logic [NX-1:0] col_parity(input logic [LINE_W-1:0] s);
    logic [NX-1:0] c;
    c = '0;
    for (int x = 0; x < NX; x++) begin
      for (int y = 0; y < NY; y++) begin
        c[x] = c[x] ^ s[NX*y + x];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/colpar_theta_slice.sv
// Combinational theta mix of one 25-bit slice given its own and the previous slice's column parity.
module colpar_theta_slice
  import colpar_pkg::*;
(
  input  logic [LINE_W-1:0] slice,
  input  logic [NX-1:0]     c_cur,
  input  logic [NX-1:0]     c_prev,
  output logic [LINE_W-1:0] theta
);

  for (genvar y = 0; y < NY; y++) begin : g_row
    for (genvar x = 0; x < NX; x++) begin : g_col
      assign theta[NX*y + x] = slice[NX*y + x] ^ c_cur[(x + 4) % NX] ^ c_prev[(x + 1) % NX];
    end
  end

endmodule

// File: rtl/colparity_stream.sv
// Slice-serial Keccak theta engine: one frame of LANE_W slices per start, output order 1..LANE_W-1,0.
// Optional COLPAR_BYPASS_EN adds a per-frame bypass input that passes slices through unchanged.
module colparity_stream
  import colpar_pkg::*;
#(
  parameter int unsigned LANE_W = 64,
  parameter int unsigned IDX_W  = $clog2(LANE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef COLPAR_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] line_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] write_value,
  output logic [IDX_W-1:0]  write_addr,
  output logic [IDX_W:0]    cnt_value,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(LANE_W - 1);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(LANE_W);

  state_t             state;
  logic               wrap_loaded;
  logic [LINE_W-1:0]  hold;
  logic [NX-1:0]      c0;
  logic [NX-1:0]      c_prev;
  logic [NX-1:0]      c_in;
  logic [LINE_W-1:0]  th_slice;
  logic [NX-1:0]      th_ccur;
  logic [LINE_W-1:0]  th_out;
  logic [LINE_W-1:0]  nxt_value;
  logic [IDX_W:0]     cnt_inc;
  logic               out_free;
  logic               accept;

  assign c_in     = col_parity(line_in);
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == LOAD0) || ((state == STREAM) && out_free);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign cnt_inc  = (cnt_value == FULL_CNT) ? cnt_value : cnt_value + (IDX_W+1)'(1);

  // The wrap-around slice 0 is mixed from the held copy once the last slice has set c_prev
  always_comb begin
    th_slice = line_in;
    th_ccur  = c_in;
    if (state == FLUSH) begin
      th_slice = hold;
      th_ccur  = c0;
    end
  end

  colpar_theta_slice u_theta (
    .slice  (th_slice),
    .c_cur  (th_ccur),
    .c_prev (c_prev),
    .theta  (th_out)
  );

`ifdef COLPAR_BYPASS_EN
  logic byp_r;
  assign nxt_value = byp_r ? th_slice : th_out;
`else
  assign nxt_value = th_out;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wrap_loaded <= 1'b0;
      hold        <= '0;
      c0          <= '0;
      c_prev      <= '0;
      out_valid   <= 1'b0;
      write_value <= '0;
      write_addr  <= '0;
      cnt_value   <= '0;
      done        <= 1'b0;
`ifdef COLPAR_BYPASS_EN
      byp_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt_value <= '0;
            state     <= LOAD0;
`ifdef COLPAR_BYPASS_EN
            byp_r     <= bypass;
`endif
          end
        end
        LOAD0: begin
          if (accept) begin
            hold      <= line_in;
            c0        <= c_in;
            c_prev    <= c_in;
            cnt_value <= cnt_inc;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            write_value <= nxt_value;
            write_addr  <= cnt_value[IDX_W-1:0];
            out_valid   <= 1'b1;
            c_prev      <= c_in;
            cnt_value   <= cnt_inc;
            if (cnt_value == LAST_IDX) state <= FLUSH;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (!wrap_loaded) begin
            if (out_free) begin
              write_value <= nxt_value;
              write_addr  <= '0;
              out_valid   <= 1'b1;
              wrap_loaded <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid   <= 1'b0;
            wrap_loaded <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
